// File: rtl/mem_write_checker.sv
// Watches a CPU's data-memory write port and checks it against a small table of
// expected {address, data} writes, reporting pass/fail, hit count and elapsed cycles.
module mem_write_checker #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NCHK    = 4,
   parameter int ORDERED = 1,
   parameter int TIMEOUT = 1024,
   localparam int CW     = $clog2(TIMEOUT+1),
   localparam int IW     = (NCHK > 1) ? $clog2(NCHK) : 1,
   localparam int HW     = $clog2(NCHK+1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic [AW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   input  logic          start,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [HW-1:0] hit_count,
   output logic [CW-1:0] cycles,
   output logic [1:0]    fail_code
);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   state_t                   state, state_d;
   logic [NCHK-1:0]          vld, hit, hit_d;
   logic [NCHK-1:0][AW-1:0]  tbl_addr;
   logic [NCHK-1:0][DW-1:0]  tbl_data;
   logic [NCHK-1:0]          pend, amatch, fmatch, tgt, first, sel;
   logic                     seen_p, seen_f, mism, oerr;
   logic [HW-1:0]            hc_d;
   logic [CW-1:0]            cyc_d;
   logic [1:0]               fc_d;

   // Only entries still waiting for their write take part in matching.
   always_comb begin
      pend   = vld & ~hit;
      amatch = '0;
      fmatch = '0;
      tgt    = '0;
      first  = '0;
      seen_p = 1'b0;
      seen_f = 1'b0;
      for (int i = 0; i < NCHK; i++) begin
         amatch[i] = pend[i] && (tbl_addr[i] == dataadr);
         fmatch[i] = amatch[i] && (tbl_data[i] == writedata);
         if (pend[i] && !seen_p) begin
            tgt[i] = 1'b1;
            seen_p = 1'b1;
         end
         if (fmatch[i] && !seen_f) begin
            first[i] = 1'b1;
            seen_f   = 1'b1;
         end
      end
      if (ORDERED != 0) begin
         sel  = tgt & fmatch;
         mism = |(tgt & amatch & ~fmatch);
         oerr = !(|(tgt & amatch)) && |(amatch & ~tgt);
      end else begin
         sel  = first;
         mism = |amatch && !(|fmatch);
         oerr = 1'b0;
      end
   end

   always_comb begin
      state_d = state;
      hit_d   = hit;
      hc_d    = hit_count;
      cyc_d   = cycles;
      fc_d    = fail_code;
      case (state)
         RUN: begin
            if (cycles != CW'(TIMEOUT)) cyc_d = cycles + CW'(1);
            if (memwrite && |sel) begin
               hit_d = hit | sel;
               hc_d  = hit_count + HW'(1);
            end
            // Errors outrank timeout; a final hit outranks timeout.
            if (memwrite && mism) begin
               state_d = FAIL;
               fc_d    = 2'b10;
            end else if (memwrite && oerr) begin
               state_d = FAIL;
               fc_d    = 2'b11;
            end else if ((vld & ~hit_d) == '0) begin
               state_d = PASS;
            end else if (cyc_d == CW'(TIMEOUT)) begin
               state_d = FAIL;
               fc_d    = 2'b01;
            end
         end
         default: begin
            if (start) begin
               hit_d   = '0;
               hc_d    = '0;
               cyc_d   = '0;
               fc_d    = 2'b00;
               state_d = (|vld) ? RUN : PASS;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         hit       <= '0;
         hit_count <= '0;
         cycles    <= '0;
         fail_code <= 2'b00;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         state     <= state_d;
         hit       <= hit_d;
         hit_count <= hc_d;
         cycles    <= cyc_d;
         fail_code <= fc_d;
         busy      <= (state_d == RUN);
         done      <= (state_d == PASS) || (state_d == FAIL);
         pass      <= (state_d == PASS);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
      end else if (cfg_we && state != RUN) begin
         for (int i = 0; i < NCHK; i++)
            if (IW'(i) == cfg_idx) vld[i] <= 1'b1;
      end
   end

   // Payload needs no reset: it is only consulted where vld is set.
   always_ff @(posedge clk) begin
      if (cfg_we && state != RUN) begin
         for (int i = 0; i < NCHK; i++) begin
            if (IW'(i) == cfg_idx) begin
               tbl_addr[i] <= cfg_addr;
               tbl_data[i] <= cfg_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives an ordered and an unordered checker with the same stimulus and compares
// both against a procedural reference model every cycle.
module tb_mem_write_checker;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0, cfg_data = '0;
   logic        start = 1'b0, memwrite = 1'b0;
   logic [31:0] dataadr = '0, writedata = '0;
   logic        busy_o [2];
   logic        done_o [2];
   logic        pass_o [2];
   logic [2:0]  hc_o   [2];
   logic [4:0]  cyc_o  [2];
   logic [1:0]  fc_o   [2];

   int npass = 0, nfail = 0, nchk = 0;

   // model state: 0 idle, 1 run, 2 pass, 3 fail; index 0 = ordered, 1 = any order
   int          m_st [2];
   bit          m_v  [2][4];
   bit          m_h  [2][4];
   logic [31:0] m_a  [2][4];
   logic [31:0] m_d  [2][4];
   int          m_hc [2], m_cy [2], m_fc [2];

   always #5 clk = ~clk;

   mem_write_checker #(.AW(32), .DW(32), .NCHK(4), .ORDERED(1), .TIMEOUT(TO)) u_ord (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .busy(busy_o[0]), .done(done_o[0]),
      .pass(pass_o[0]), .hit_count(hc_o[0]), .cycles(cyc_o[0]), .fail_code(fc_o[0]));

   mem_write_checker #(.AW(32), .DW(32), .NCHK(4), .ORDERED(0), .TIMEOUT(TO)) u_any (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .busy(busy_o[1]), .done(done_o[1]),
      .pass(pass_o[1]), .hit_count(hc_o[1]), .cycles(cyc_o[1]), .fail_code(fc_o[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_hc[d] = 0; m_cy[d] = 0; m_fc[d] = 0;
         for (int i = 0; i < 4; i++) begin
            m_v[d][i] = 0;
            m_h[d][i] = 0;
         end
      end
   endtask

   task automatic model_step(input int d);
      if (m_st[d] != 1) begin
         if (start) begin
            int nv = 0;
            for (int i = 0; i < 4; i++) begin
               m_h[d][i] = 0;
               if (m_v[d][i]) nv++;
            end
            m_hc[d] = 0; m_cy[d] = 0; m_fc[d] = 0;
            m_st[d] = (nv == 0) ? 2 : 1;
         end
         if (cfg_we) begin
            m_v[d][cfg_idx] = 1;
            m_a[d][cfg_idx] = cfg_addr;
            m_d[d][cfg_idx] = cfg_data;
         end
      end else begin
         int hit_i = -1;
         int err = 0;
         int left = 0;
         if (m_cy[d] < TO) m_cy[d]++;
         if (memwrite) begin
            if (d == 0) begin
               int t = -1;
               for (int i = 0; i < 4; i++)
                  if (t < 0 && m_v[d][i] && !m_h[d][i]) t = i;
               if (t >= 0 && dataadr == m_a[d][t]) begin
                  if (writedata == m_d[d][t]) hit_i = t;
                  else err = 2;
               end else begin
                  for (int i = 0; i < 4; i++)
                     if (m_v[d][i] && !m_h[d][i] && dataadr == m_a[d][i]) err = 3;
               end
            end else begin
               for (int i = 0; i < 4; i++)
                  if (hit_i < 0 && m_v[d][i] && !m_h[d][i] &&
                      dataadr == m_a[d][i] && writedata == m_d[d][i]) hit_i = i;
               if (hit_i < 0)
                  for (int i = 0; i < 4; i++)
                     if (m_v[d][i] && !m_h[d][i] && dataadr == m_a[d][i]) err = 2;
            end
         end
         if (hit_i >= 0) begin
            m_h[d][hit_i] = 1;
            m_hc[d]++;
         end
         for (int i = 0; i < 4; i++)
            if (m_v[d][i] && !m_h[d][i]) left++;
         if (err != 0) begin
            m_st[d] = 3; m_fc[d] = err;
         end else if (left == 0) begin
            m_st[d] = 2;
         end else if (m_cy[d] == TO) begin
            m_st[d] = 3; m_fc[d] = 1;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_busy"}, 32'(busy_o[d]), 32'(m_st[d] == 1));
         chk({tag, "_done"}, 32'(done_o[d]), 32'(m_st[d] >= 2));
         chk({tag, "_pass"}, 32'(pass_o[d]), 32'(m_st[d] == 2));
         chk({tag, "_hits"}, 32'(hc_o[d]),   32'(m_hc[d]));
         chk({tag, "_cyc"},  32'(cyc_o[d]),  32'(m_cy[d]));
         chk({tag, "_code"}, 32'(fc_o[d]),   32'(m_fc[d]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all("cyc");
      start = 0; cfg_we = 0; memwrite = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] dd);
      cfg_we = 1; cfg_idx = idx[1:0]; cfg_addr = a; cfg_data = dd;
      tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] dd);
      memwrite = 1; dataadr = a; writedata = dd;
      tick();
   endtask

   task automatic go();
      start = 1;
      tick();
   endtask

   // Asserted mid-cycle so the bench sees the asynchronous clear before any edge.
   task automatic do_reset();
      #3 reset_n = 0;
      #1 model_reset();
      compare_all("rst");
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      model_reset();
      #2 compare_all("por");
      @(negedge clk);
      reset_n = 1;

      // single entry hit on the fifth RUN cycle
      cfg(0, 84, 32'h96);
      go();
      idle(4);
      wr(84, 32'h96);
      chk("single_pass", 32'(pass_o[0]), 1);
      chk("single_cyc",  32'(cyc_o[0]), 5);
      chk("single_hits", 32'(hc_o[1]), 1);
      chk("single_code", 32'(fc_o[0]), 0);

      // unrelated write ignored, then data mismatch
      go();
      wr(88, 32'h96);
      chk("unrel_busy", 32'(busy_o[0]), 1);
      wr(84, 32'h95);
      chk("mism_code_o", 32'(fc_o[0]), 2);
      chk("mism_code_a", 32'(fc_o[1]), 2);

      // out-of-order writes
      do_reset();
      cfg(0, 32'h10, 1);
      cfg(1, 32'h14, 2);
      go();
      wr(32'h14, 2);
      chk("order_code", 32'(fc_o[0]), 3);
      chk("order_hits", 32'(hc_o[0]), 0);
      wr(32'h10, 1);
      chk("any_pass", 32'(pass_o[1]), 1);
      chk("any_hits", 32'(hc_o[1]), 2);
      chk("order_hold", 32'(fc_o[0]), 3);

      // timeout, then final hit landing on the timeout edge
      go();
      idle(TO);
      chk("to_code", 32'(fc_o[0]), 1);
      chk("to_cyc",  32'(cyc_o[1]), TO);
      go();
      idle(2);
      wr(32'h10, 1);
      idle(TO - 4);
      wr(32'h14, 2);
      chk("edge_pass_o", 32'(pass_o[0]), 1);
      chk("edge_pass_a", 32'(pass_o[1]), 1);
      chk("edge_cyc",    32'(cyc_o[0]), TO);

      // table write during RUN has no effect
      go();
      cfg(2, 32'h20, 3);
      wr(32'h10, 1);
      wr(32'h14, 2);
      chk("runcfg_pass", 32'(pass_o[0]), 1);
      go();
      wr(32'h10, 1);
      wr(32'h14, 2);
      chk("runcfg_pass2", 32'(pass_o[1]), 1);

      // reset mid-RUN, then start with an empty table
      go();
      idle(2);
      do_reset();
      chk("rst_busy", 32'(busy_o[0]), 0);
      chk("rst_cyc",  32'(cyc_o[0]), 0);
      go();
      chk("empty_pass", 32'(pass_o[0]), 1);
      chk("empty_hits", 32'(hc_o[0]), 0);

      // randomized rounds over a small address/data pool to force collisions
      for (int r = 0; r < 30; r++) begin
         int n;
         do_reset();
         n = $urandom_range(0, 4);
         for (int k = 0; k < n; k++)
            cfg($urandom_range(0, 3), 32'h40 + 4 * $urandom_range(0, 3), $urandom_range(0, 2));
         go();
         for (int c = 0; c < 22; c++) begin
            int p = $urandom_range(0, 99);
            if (p < 5) begin
               start = 1;
            end else if (p < 10) begin
               cfg_we = 1; cfg_idx = 2'($urandom_range(0, 3));
               cfg_addr = 32'h40 + 4 * $urandom_range(0, 3);
               cfg_data = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 99) < 60) begin
               memwrite = 1;
               dataadr = 32'h40 + 4 * $urandom_range(0, 4);
               writedata = $urandom_range(0, 2);
            end
            tick();
         end
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
